// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters.
// Optional build macro ALU_ARB_DIV0_TRAP_EN: divide (sel 4'b0011) by zero is answered with 'hFF
// instead of being issued to the ALU.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state;
    logic             ptr;
    logic             id;
    logic             trap;
    logic             any;
    logic             grant;
    logic             div0;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [SEL_W-1:0] sel_op;
    // the pointer only breaks ties; a lone requester always wins
    assign any        = req0_valid || req1_valid;
    assign grant      = (req0_valid && req1_valid) ? ptr : !req0_valid;
    assign req0_ready = rst_n && state == IDLE && req0_valid && !grant;
    assign req1_ready = rst_n && state == IDLE && req1_valid && grant;
    assign sel_a      = grant ? req1_a : req0_a;
    assign sel_b      = grant ? req1_b : req0_b;
    assign sel_op     = grant ? req1_sel : req0_sel;
`ifdef ALU_ARB_DIV0_TRAP_EN
    assign div0 = sel_op == SEL_W'(3) && sel_b == '0;
`else
    assign div0 = 1'b0;
`endif
    // accept one operation, give the ALU one cycle to settle, then hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            id        <= 1'b0;
            trap      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    if (!div0) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_sel <= sel_op;
                    end
                    id    <= grant;
                    trap  <= div0;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_data  <= trap ? '1 : alu_out;
                    rsp_carry <= !trap && alu_carry;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    ptr       <= ~rsp_id;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (A, B, 4-bit select → 8-bit result + carry) between two requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Drives the ALU operand/select inputs from internal registers, captures the ALU result and returns it tagged with the requester ID.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU.
- SEL_W, 4, ALU opcode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as above, for requester 1.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_sel  out  SEL_W  registered opcode to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_id  out  1  requester the response belongs to (0 or 1).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; priority pointer = 0.
  - alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_id, rsp_valid all 0.
  - req0_ready and req1_ready = 0 while in reset.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - reqN_ready is combinational, = (state==IDLE) && (grant==N); never both high.
  - On the handshake edge: latch reqN_a/b/sel into alu_a/b/sel, latch N into the ID register, go to EXEC.
  - No valid: stay in IDLE; ALU registers hold their last values.
- EXEC (exactly 1 cycle; the ALU settles combinationally from the registers):
  - Capture alu_out → rsp_data and alu_carry → rsp_carry; rsp_id = latched ID.
  - rsp_valid ← 1; go to RESP.
- RESP:
  - rsp_valid stays high; rsp_data/rsp_carry/rsp_id are stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready edge: rsp_valid ← 0, pointer ← ~rsp_id, go to IDLE.
  - No request is accepted while in EXEC or RESP (single outstanding operation).
- Latency: request handshake at edge T → rsp_valid high after edge T+1. With rsp_ready held high, the response is consumed at edge T+2 and the next grant can happen at edge T+3. Peak throughput is one operation per 3 cycles.
- The pointer changes only on response completion, so a requester holding valid continuously cannot starve the other.
- A requester may drop valid without a handshake; no state is affected.
- Operand/opcode changes on the request ports after acceptance have no effect.
- Reset mid-EXEC or mid-RESP: the operation is discarded and no response is produced.

Optional Feature:
- Macro: ALU_ARB_DIV0_TRAP_EN.
- Defined: an accepted request with sel==4'b0011 and b==0 is not passed to the ALU.
  - alu_a/b/sel keep their previous values.
  - The EXEC capture is replaced by rsp_data=8'hFF, rsp_carry=0.
  - Same 2-cycle latency, same handshake.
- Undefined: divide-by-zero is issued like any other operation; rsp_data is whatever the ALU produces.

Test Plan:
- Reset, then req0 = (A=8'h05, B=8'h03, sel=0000), rsp_ready=1 → req0_ready pulses 1 cycle; two edges later rsp_valid=1, rsp_data=8'h08, rsp_carry=0, rsp_id=0.
- Carry case: req1 = (A=8'hFF, B=8'h02, sel=0000) → rsp_data=8'h01, rsp_carry=1, rsp_id=1.
- Both valid continuously, pointer=0 after reset, rsp_ready=1 → grants alternate 0,1,0,1; four responses with rsp_id 0,1,0,1, each spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_id stable; both reqN_ready stay 0 while req1_valid=1; response completes on the cycle rsp_ready rises.
- Reset asserted during RESP → rsp_valid drops to 0 immediately (asynchronously); no response after release; next grant goes to req0.
- Macro defined: req0 = (A=8'h10, B=8'h00, sel=0011) → rsp_data=8'hFF, rsp_carry=0, alu_sel unchanged. Macro undefined: the same request is issued and alu_sel becomes 4'b0011.
